fft_band_accum: RTL
===================

Name: fft_band_accum

Overview:
- Downstream consumer of dft_top (1024-point streaming FFT; 2 complex words per cycle; 512 cycles per frame; next_out pulses one cycle before output word 0).
- Computes an approximate magnitude for each of the 512 non-redundant bins (0..511).
- Averages those magnitudes into NUM_BANDS linear frequency bands.
- Holds the last complete band set for the visualiser logic through a registered read port.

Parameters:
- DATA_W, 16, width of each Y word (signed two's complement).
- BAND_SHIFT, 5, log2 of bins per band. Legal range 1..8. NUM_BANDS = 512 >> BAND_SHIFT (default 16).
- BAND_IDX_W, $clog2(NUM_BANDS), width of the read address.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- next_out  in  1  from dft_top; frame data word 0 arrives on the following cycle.
- Y0  in  DATA_W  real part, bin 2c.
- Y1  in  DATA_W  imag part, bin 2c.
- Y2  in  DATA_W  real part, bin 2c+1.
- Y3  in  DATA_W  imag part, bin 2c+1.
- rd_band  in  BAND_IDX_W  band read address.
- rd_val  out  DATA_W  unsigned band average, 1-cycle read latency.
- frame_done  out  1  one-cycle pulse when the held band set updates.
- overrun  out  1  sticky; a frame was aborted.

Behaviour:
- Clock and reset:
  - Single clock; reset is synchronous, active-high.
  - Reset clears FSM to IDLE, cycle counter, working and held accumulators, pipeline valids, rd_val, frame_done and overrun.
  - Reset mid-frame discards the frame; no frame_done follows.
- FSM:
  - IDLE: on next_out -> CAPTURE, c=0, working accumulators cleared.
  - CAPTURE: c increments each cycle. At c=0..255, the data on Y0..Y3 is bins 2c and 2c+1; it is pushed into the pipeline. At c=256..511 the data is mirror bins and is ignored. At c=511 -> IDLE.
  - next_out during CAPTURE with c>=256: starts a new frame (c=0 next cycle); no error.
  - next_out during CAPTURE with c<256: current frame aborted, working accumulators cleared, in-flight pipeline valids killed, overrun set, new frame starts (c=0 next cycle).
- Magnitude pipeline (fft_mag_approx, 2 stages):
  - Stage 1: abs of each part; -32768 saturates to 32767.
  - Stage 2: mag = max + (min >> 1), unsigned 16-bit; maximum 49150, so no overflow.
- Accumulate (stage 3):
  - band = bin >> BAND_SHIFT. Both bins of a cycle always fall in the same band because BAND_SHIFT >= 1.
  - acc[band] += magA + magB.
  - Accumulator width is 16 + BAND_SHIFT; it cannot overflow.
- Commit:
  - The bin pair from c=255 finishes stage 3 at t0+259, where t0 is the next_out cycle.
  - In that same cycle, held[b] <= acc[b] >> BAND_SHIFT, and frame_done=1 for exactly one cycle.
  - Held values are valid while frame_done is high.
  - A frame aborted before commit never updates held.
- Read port:
  - rd_val <= held[rd_band] registered; 1-cycle latency; continuous.
  - Reading the same cycle as a commit returns the old value; the new value appears from the next read.
- Latency: next_out to frame_done = 259 cycles (fixed).

Optional Feature:
- Macro: FFT_BAND_DC_REJECT_EN.
- Defined: bin 0 magnitude is forced to 0 before accumulation. Band 0 then averages bins 1..31 over 32 (divisor unchanged).
- Undefined: bin 0 is accumulated like every other bin.
- Latency and interface are identical either way.

Decomposition:
- Package fft_band_pkg holds:
  - constants FFT_N=1024, CYCLES_PER_FRAME=512, USED_CYCLES=256, DATA_W=16;
  - typedef state_t {IDLE, CAPTURE};
  - typedef mag_t (unsigned 16-bit).
- Sub-module fft_mag_approx: one complex word in, 2-stage abs + alpha-max-beta-min, valid in/out.
- Two instances of fft_mag_approx serve the two lanes.

Test Plan:
- Single tone:
  - Stimulus: next_out; at c=20 Y2=1000, Y3=0 (bin 41); all else 0.
  - Required: frame_done at t0+259; band 1 reads 1000>>5 = 31; all other bands 0; overrun 0.
- Alpha-max-beta-min and saturation:
  - Stimulus: bin 2 with Y0=-32768, Y1=-32768; all else 0.
  - Required: mag 49150; band 0 reads 49150>>5 = 1535.
- Full-scale flat:
  - Stimulus: every used bin Y real=30000, imag=0.
  - Required: all 16 bands read 30000.
  - With FFT_BAND_DC_REJECT_EN defined: band 0 reads 29062.
- Mirror half ignored:
  - Stimulus: nonzero data only at c=256..511.
  - Required: all bands 0; frame_done still pulses.
- Abort:
  - Stimulus: second next_out at c=100.
  - Required: overrun=1; no frame_done at the first frame's t0+259; frame_done at the second frame's t0+259 with only second-frame data.
  - A second next_out at c=300 must instead give overrun=0 and both frames committing.
- Reset mid-CAPTURE:
  - Stimulus: reset at c=150.
  - Required: rd_val=0 for all bands; no frame_done; the next frame works normally.

Source files
------------

// File: rtl/fft_band_pkg.sv
// fft_band_pkg: shared constants, types and helpers for the FFT band accumulator.
package fft_band_pkg;
  localparam int FFT_N = 1024;
  localparam int CYCLES_PER_FRAME = FFT_N / 2;
  localparam int USED_CYCLES = CYCLES_PER_FRAME / 2;
  localparam int DATA_W = 16;
  typedef enum logic {IDLE, CAPTURE} state_t;
  typedef logic [DATA_W-1:0] mag_t;
  // The most negative input has no positive twin, so it clamps to the largest positive value.
  function automatic mag_t sat_abs(input logic signed [DATA_W-1:0] x);
    return (x == {1'b1, {(DATA_W-1){1'b0}}}) ? {1'b0, {(DATA_W-1){1'b1}}} :
           x[DATA_W-1] ? mag_t'(-x) : mag_t'(x);
  endfunction
endpackage

// File: rtl/fft_mag_approx.sv
// fft_mag_approx: 2-stage saturating abs plus alpha-max-beta-min magnitude of one complex word.
module fft_mag_approx
  import fft_band_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] re,
  input  logic signed [DATA_W-1:0] im,
  output logic                     out_valid,
  output mag_t                     mag
);
  mag_t abs_re, abs_im, mx, mn;
  logic v_q;
  always_comb begin
    mx = (abs_re > abs_im) ? abs_re : abs_im;
    mn = (abs_re > abs_im) ? abs_im : abs_re;
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      v_q       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v_q       <= in_valid;
      out_valid <= v_q;
    end
  end
  // Largest result is 32767 + 16383, which still fits the 16-bit magnitude.
  always_ff @(posedge clk) begin
    abs_re <= sat_abs(re);
    abs_im <= sat_abs(im);
    mag    <= mx + (mn >> 1);
  end
endmodule

// File: rtl/fft_band_accum.sv
// fft_band_accum: per-bin magnitude averaged into linear bands, held set read through a registered port.
// Define FFT_BAND_DC_REJECT_EN to zero the bin 0 magnitude before accumulation.
module fft_band_accum #(
  parameter int DATA_W     = 16,
  parameter int BAND_SHIFT = 5,
  parameter int BAND_IDX_W = $clog2(512 >> BAND_SHIFT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     next_out,
  input  logic signed [DATA_W-1:0] Y0,
  input  logic signed [DATA_W-1:0] Y1,
  input  logic signed [DATA_W-1:0] Y2,
  input  logic signed [DATA_W-1:0] Y3,
  input  logic [BAND_IDX_W-1:0]    rd_band,
  output logic [DATA_W-1:0]        rd_val,
  output logic                     frame_done,
  output logic                     overrun
);
  import fft_band_pkg::*;
  localparam int NUM_BANDS = 512 >> BAND_SHIFT;
  localparam int ACC_W = 16 + BAND_SHIFT;
  state_t state, state_n;
  logic [8:0] c, c_n;
  logic in_cap, push, abort;
  logic [7:0] idx1, idx2;
  logic v_a, v_b, v, commit;
  mag_t mag_a, mag_b, mag_a_eff;
  logic [ACC_W-1:0] sum;
  logic [BAND_IDX_W-1:0] band;
  logic [ACC_W-1:0] acc [NUM_BANDS];
  logic [ACC_W-1:0] acc_n [NUM_BANDS];
  logic [DATA_W-1:0] held [NUM_BANDS];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      c     <= '0;
    end else begin
      state <= state_n;
      c     <= c_n;
    end
  end
  // A new next_out always restarts the count; only its timing decides whether it is an abort.
  always_comb begin
    state_n = next_out ? CAPTURE : (state == CAPTURE && c == 9'(CYCLES_PER_FRAME - 1)) ? IDLE : state;
    c_n     = next_out ? '0 : (state == CAPTURE) ? c + 9'd1 : c;
  end
  always_comb begin
    in_cap = (state == CAPTURE) && (c < 9'(USED_CYCLES));
    push   = in_cap && !next_out;
    abort  = in_cap && next_out;
  end
  always_ff @(posedge clk) begin
    idx1 <= c[7:0];
    idx2 <= idx1;
  end
  fft_mag_approx u_mag_a (
    .clk(clk), .reset(reset), .flush(abort), .in_valid(push),
    .re(Y0), .im(Y1), .out_valid(v_a), .mag(mag_a)
  );
  fft_mag_approx u_mag_b (
    .clk(clk), .reset(reset), .flush(abort), .in_valid(push),
    .re(Y2), .im(Y3), .out_valid(v_b), .mag(mag_b)
  );
  // The first bin pair of a frame overwrites rather than adds, so stale sums never leak in.
  always_comb begin
`ifdef FFT_BAND_DC_REJECT_EN
    mag_a_eff = (idx2 == 8'd0) ? '0 : mag_a;
`else
    mag_a_eff = mag_a;
`endif
    v      = v_a & v_b;
    commit = v && (idx2 == 8'(USED_CYCLES - 1));
    sum    = ACC_W'(mag_a_eff) + ACC_W'(mag_b);
    band   = BAND_IDX_W'(idx2 >> (BAND_SHIFT - 1));
    for (int b = 0; b < NUM_BANDS; b++)
      acc_n[b] = ((idx2 == 8'd0) ? '0 : acc[b]) + ((band == BAND_IDX_W'(b)) ? sum : '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        acc[b]  <= '0;
        held[b] <= '0;
      end
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      rd_val     <= '0;
    end else begin
      frame_done <= commit;
      overrun    <= overrun | abort;
      rd_val     <= held[rd_band];
      for (int b = 0; b < NUM_BANDS; b++) begin
        acc[b] <= abort ? '0 : v ? acc_n[b] : acc[b];
        if (commit) held[b] <= DATA_W'(acc_n[b] >> BAND_SHIFT);
      end
    end
  end
endmodule
